// File: rtl/exc_flush_ctrl.sv
// Exception/ERET sequencer: pulses CP0, drains outstanding bus traffic, flushes the
// pipeline for a fixed number of cycles, then hands the target PC to fetch.
module exc_flush_ctrl #(
  parameter int unsigned             TYPE_W       = 4,
  parameter logic [TYPE_W-1:0]       ERET_CODE    = TYPE_W'(9),
  parameter int unsigned             FLUSH_CYCLES = 2,
  parameter int unsigned             DRAIN_MAX    = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exc_flag_i,
  input  logic [TYPE_W-1:0] exc_type_i,
  input  logic [31:0]       exc_pc_i,
  input  logic [31:0]       flush_pc_i,
  input  logic              ibus_busy_i,
  input  logic              dbus_busy_i,
  input  logic              redirect_ready_i,
  output logic              cp0_exc_we_o,
  output logic              cp0_eret_o,
  output logic [TYPE_W-1:0] cp0_type_o,
  output logic [31:0]       cp0_pc_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o,
  output logic              busy_o,
  output logic              drain_timeout_o
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_MAX + 1);
  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_REDIR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         target_q, target_d;
  logic                exc_we_q, exc_we_d;
  logic                eret_q, eret_d;
  logic                timeout_q, timeout_d;
  logic                bus_busy;
  logic                accept;

  assign bus_busy = ibus_busy_i | dbus_busy_i;
  assign accept   = exc_flag_i && (exc_type_i != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      flush_cnt_q <= '0;
      type_q      <= '0;
      pc_q        <= '0;
      target_q    <= '0;
      exc_we_q    <= 1'b0;
      eret_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      type_q      <= type_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      exc_we_q    <= exc_we_d;
      eret_q      <= eret_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    flush_cnt_d = flush_cnt_q;
    type_d      = type_q;
    pc_d        = pc_q;
    target_d    = target_q;
    exc_we_d    = 1'b0;
    eret_d      = 1'b0;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d      = exc_type_i;
          pc_d        = exc_pc_i;
          target_d    = flush_pc_i;
          eret_d      = (exc_type_i == ERET_CODE);
          exc_we_d    = (exc_type_i != ERET_CODE);
          drain_cnt_d = '0;
          flush_cnt_d = '0;
          state_d     = bus_busy ? S_DRAIN : S_FLUSH;
        end
      end
      S_DRAIN: begin
        // The watchdog forces progress so a hung bus cannot wedge exception entry.
        if (!bus_busy) begin
          drain_cnt_d = '0;
          state_d     = S_FLUSH;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_MAX - 1)) begin
          drain_cnt_d = '0;
          timeout_d   = 1'b1;
          state_d     = S_FLUSH;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
          flush_cnt_d = '0;
          state_d     = S_REDIR;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_REDIR: begin
        if (redirect_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs are registers or pure state decodes; no input reaches an output.
  assign cp0_exc_we_o     = exc_we_q;
  assign cp0_eret_o       = eret_q;
  assign cp0_type_o       = type_q;
  assign cp0_pc_o         = pc_q;
  assign stall_o          = (state_q == S_DRAIN) || (state_q == S_FLUSH);
  assign flush_o          = (state_q == S_FLUSH);
  assign redirect_valid_o = (state_q == S_REDIR);
  assign redirect_pc_o    = target_q;
  assign busy_o           = (state_q != S_IDLE);
  assign drain_timeout_o  = timeout_q;

endmodule
